// File: rtl/ald_plant_pkg.sv
// Shared types and defaults for the ALD reactor plant emulator.
package ald_plant_pkg;

   typedef enum logic [1:0] {
      PUMP_OFF      = 2'd0,
      PUMP_SPINUP   = 2'd1,
      PUMP_READY    = 2'd2,
      PUMP_SPINDOWN = 2'd3
   } pump_state_t;

   localparam int P_W_DEF          = 12;
   localparam int P_ATM_DEF        = 4000;
   localparam int P_VAC_TH_DEF     = 64;
   localparam int P_ATM_TH_DEF     = 3900;
   localparam int PUMP_SHIFT_DEF   = 4;
   localparam int MFC_STEP_DEF     = 2;
   localparam int DOSE_STEP_DEF    = 40;
   localparam int T_W_DEF          = 10;
   localparam int T_AMB_DEF        = 25;
   localparam int T_SET_DEF        = 250;
   localparam int T_HYST_DEF       = 5;
   localparam int HEAT_DIV_DEF     = 4;
   localparam int COOL_DIV_DEF     = 16;
   localparam int SPINUP_TICKS_DEF = 2000;

   // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ald_plant_pump_fsm.sv
// Turbo pump model: spin-up / ready / spin-down sequencing on the 1 kHz tick.
module ald_plant_pump_fsm
   import ald_plant_pkg::*;
#(
   parameter int SPINUP_TICKS = SPINUP_TICKS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       pump_en,
   output logic [1:0] state
);
   localparam int CW = $clog2(SPINUP_TICKS);
   // The tick that enters a phase counts as its first tick, hence the -2.
   localparam logic [CW-1:0] UP_LAST = CW'(SPINUP_TICKS - 2);
   localparam logic [CW-1:0] DN_LAST = CW'(SPINUP_TICKS / 2 - 2);

   pump_state_t     state_q, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PUMP_OFF;
         cnt     <= '0;
      end else begin
         state_q <= state_nxt;
         cnt     <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt;
      if (tick) begin
         case (state_q)
            PUMP_OFF: if (pump_en) begin
               state_nxt = PUMP_SPINUP;
               cnt_nxt   = '0;
            end
            PUMP_SPINUP: begin
               if (!pump_en) begin
                  state_nxt = PUMP_SPINDOWN;
                  cnt_nxt   = '0;
               end else if (cnt == UP_LAST) state_nxt = PUMP_READY;
               else cnt_nxt = cnt + CW'(1);
            end
            PUMP_READY: if (!pump_en) begin
               state_nxt = PUMP_SPINDOWN;
               cnt_nxt   = '0;
            end
            PUMP_SPINDOWN: begin
               if (pump_en) begin
                  state_nxt = PUMP_SPINUP;
                  cnt_nxt   = '0;
               end else if (cnt == DN_LAST) state_nxt = PUMP_OFF;
               else cnt_nxt = cnt + CW'(1);
            end
            default: state_nxt = PUMP_OFF;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: rtl/ald_plant_emulator.sv
// HIL model of the ALD reactor: pressure, temperature, pump and dose sensing.
// Optional build macro ALD_PLANT_NOISE_EN adds +/-1 LFSR noise to pressure.
module ald_plant_emulator
   import ald_plant_pkg::*;
#(
   parameter int P_W          = P_W_DEF,
   parameter int P_ATM        = P_ATM_DEF,
   parameter int P_VAC_TH     = P_VAC_TH_DEF,
   parameter int P_ATM_TH     = P_ATM_TH_DEF,
   parameter int PUMP_SHIFT   = PUMP_SHIFT_DEF,
   parameter int MFC_STEP     = MFC_STEP_DEF,
   parameter int DOSE_STEP    = DOSE_STEP_DEF,
   parameter int T_W          = T_W_DEF,
   parameter int T_AMB        = T_AMB_DEF,
   parameter int T_SET        = T_SET_DEF,
   parameter int T_HYST       = T_HYST_DEF,
   parameter int HEAT_DIV     = HEAT_DIV_DEF,
   parameter int COOL_DIV     = COOL_DIV_DEF,
   parameter int SPINUP_TICKS = SPINUP_TICKS_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tick,
   input  logic           sv1,
   input  logic           sv4,
   input  logic           vv1,
   input  logic           vv2,
   input  logic           mfc,
   input  logic           heater,
   input  logic           pump_en,
   input  logic           vent,
   output logic           pressure_switch,
   output logic           atmosphere,
   output logic           temp_ready,
   output logic           tp1,
   output logic [P_W-1:0] pressure,
   output logic [T_W-1:0] temp,
   output logic           mix_fault,
   output logic [7:0]     sv1_doses,
   output logic [7:0]     sv4_doses
);
   localparam int SW = P_W + 2;
   localparam int DW = $clog2((COOL_DIV > HEAT_DIV) ? COOL_DIV : HEAT_DIV) + 1;

   localparam logic [P_W-1:0] P_ATM_V  = P_W'(P_ATM);
   localparam logic [P_W-1:0] P_VAC_V  = P_W'(P_VAC_TH);
   localparam logic [P_W-1:0] P_ATMT_V = P_W'(P_ATM_TH);
   localparam logic [SW-1:0]  MFC_V    = SW'(MFC_STEP);
   localparam logic [SW-1:0]  DOSE_V   = SW'(DOSE_STEP);
   localparam logic [T_W-1:0] T_AMB_V  = T_W'(T_AMB);
   localparam logic [T_W-1:0] T_SET_V  = T_W'(T_SET);
   localparam logic [T_W-1:0] T_CLR_V  = T_W'(T_SET - T_HYST);
   localparam logic [DW-1:0]  HEAT_V   = DW'(HEAT_DIV);
   localparam logic [DW-1:0]  COOL_V   = DW'(COOL_DIV);

   logic [1:0]  pump_raw;
   pump_state_t pump_state;

   ald_plant_pump_fsm #(.SPINUP_TICKS(SPINUP_TICKS)) u_pump (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .pump_en (pump_en),
      .state   (pump_raw)
   );

   assign pump_state = pump_state_t'(pump_raw);
   assign tp1        = (pump_state == PUMP_READY);

   logic [SW-1:0] noise;
`ifdef ALD_PLANT_NOISE_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk) begin
      if (rst)       lfsr <= LFSR_SEED;
      else if (tick) lfsr <= lfsr_next(lfsr);
   end
   assign noise = lfsr[0] ? SW'(1) : '1;
`else
   assign noise = '0;
`endif

   logic [P_W-1:0] dec, p_nxt;
   logic [SW-1:0]  inflow, p_sum;

   // Arithmetic runs in P_W+2 bits so the sign bit catches underflow before clamping.
   always_comb begin
      dec = '0;
      if (vv1 | vv2) begin
         case (pump_state)
            PUMP_READY: dec = ((pressure >> PUMP_SHIFT) != '0) ? (pressure >> PUMP_SHIFT)
                                                                : {{(P_W-1){1'b0}}, |pressure};
            PUMP_SPINUP, PUMP_SPINDOWN: dec = pressure >> (PUMP_SHIFT + 1);
            default: dec = '0;
         endcase
      end
      inflow = (mfc ? MFC_V : '0) + (sv1 ? DOSE_V : '0) + (sv4 ? DOSE_V : '0);
      p_sum  = {2'b00, pressure} - {2'b00, dec} + inflow + noise;
      if (vent)                 p_nxt = P_ATM_V;
      else if (p_sum[SW-1])     p_nxt = '0;
      else if (|p_sum[SW-2:P_W]) p_nxt = '1;
      else                      p_nxt = p_sum[P_W-1:0];
   end

   logic           heater_q, sv1_q, sv4_q, step, trdy_nxt;
   logic [DW-1:0]  div_q, div_cur;
   logic [T_W-1:0] t_nxt;

   // A heater change restarts the divider; the changing tick counts as the first one.
   always_comb begin
      div_cur  = ((heater != heater_q) ? '0 : div_q) + DW'(1);
      step     = (div_cur == (heater ? HEAT_V : COOL_V));
      t_nxt    = temp;
      if (step && heater && (temp != '1))        t_nxt = temp + T_W'(1);
      else if (step && !heater && (temp > T_AMB_V)) t_nxt = temp - T_W'(1);
      trdy_nxt = temp_ready;
      if (t_nxt >= T_SET_V)     trdy_nxt = 1'b1;
      else if (t_nxt < T_CLR_V) trdy_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pressure        <= P_ATM_V;
         pressure_switch <= 1'b0;
         atmosphere      <= 1'b1;
         temp            <= T_AMB_V;
         temp_ready      <= 1'b0;
         div_q           <= '0;
         heater_q        <= 1'b0;
         sv1_q           <= 1'b0;
         sv4_q           <= 1'b0;
         sv1_doses       <= '0;
         sv4_doses       <= '0;
         mix_fault       <= 1'b0;
      end else if (tick) begin
         pressure        <= p_nxt;
         pressure_switch <= (p_nxt <= P_VAC_V);
         atmosphere      <= (p_nxt >= P_ATMT_V);
         temp            <= t_nxt;
         temp_ready      <= trdy_nxt;
         div_q           <= step ? '0 : div_cur;
         heater_q        <= heater;
         sv1_q           <= sv1;
         sv4_q           <= sv4;
         if (sv1 && !sv1_q && (sv1_doses != 8'hFF)) sv1_doses <= sv1_doses + 8'd1;
         if (sv4 && !sv4_q && (sv4_doses != 8'hFF)) sv4_doses <= sv4_doses + 8'd1;
         if (sv1 && sv4) mix_fault <= 1'b1;
      end
   end

endmodule
